// File: rtl/fp16_normalize_fsm.sv
`default_nettype none
// ============================================================================
// fp16_normalize_fsm : one-bit-per-cycle post-add normalizer, exponent via inc/dec unit
// Revision 1.0
// ============================================================================
module fp16_normalize_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [4:0]  exp_in,
  input  logic [11:0] sum_in,
  output logic        incdec_select,
  output logic        incdec_cin,
  output logic [4:0]  incdec_a,
  input  logic [4:0]  incdec_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [4:0]  exp_out,
  output logic [9:0]  mant_out,
  output logic        overflow,
  output logic        underflow,
  output logic        zero,
  output logic [3:0]  shift_cnt
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_CHECK   = 3'd1;
  localparam logic [2:0] c_SHIFT_R = 3'd2;
  localparam logic [2:0] c_SHIFT_L = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  localparam logic [4:0] c_EXP_MAX = 5'd31;
  localparam logic [4:0] c_EXP_MIN = 5'd1;

  logic [2:0]  r_state;
  logic        r_sign;
  logic [4:0]  r_exp;
  logic [11:0] r_mant;
  logic        r_ovf;
  logic        r_unf;
  logic        r_zero;
  logic [3:0]  r_cnt;

  logic        w_shl_active;
  logic [11:0] w_mant_shl;
  logic [11:0] w_mant_shr;

  // At exp==1 the left-shift state stops instead of stepping, so the unit is left idle.
  assign w_shl_active  = (r_state == c_SHIFT_L) && (r_exp != c_EXP_MIN);
  assign w_mant_shl    = {r_mant[10:0], 1'b0};
  assign w_mant_shr    = {1'b0, r_mant[11:1]};

  assign incdec_select = (r_state == c_SHIFT_R) || w_shl_active;
  assign incdec_cin    = w_shl_active;
  assign incdec_a      = r_exp;

  assign in_ready      = (r_state == c_IDLE);
  assign out_valid     = (r_state == c_DONE);
  assign sign_out      = r_sign;
  assign exp_out       = r_exp;
  assign mant_out      = r_mant[9:0];
  assign overflow      = r_ovf;
  assign underflow     = r_unf;
  assign zero          = r_zero;
  assign shift_cnt     = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= 5'd0;
      r_mant  <= 12'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_zero  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_sign  <= sign_in;
            r_exp   <= exp_in;
            r_mant  <= sum_in;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_zero  <= 1'b0;
            r_cnt   <= 4'd0;
            r_state <= c_CHECK;
          end
        end
        c_CHECK: begin
          if (r_mant == 12'd0) begin
            r_zero  <= 1'b1;
            r_exp   <= 5'd0;
            r_state <= c_DONE;
          end else if (r_exp == c_EXP_MAX) begin
            r_ovf   <= 1'b1;
            r_mant  <= 12'd0;
            r_state <= c_DONE;
          end else if (r_exp == 5'd0) begin
            r_state <= c_DONE;
          end else if (r_mant[11]) begin
            r_state <= c_SHIFT_R;
          end else if (r_mant[10]) begin
            r_state <= c_DONE;
          end else begin
            r_state <= c_SHIFT_L;
          end
        end
        c_SHIFT_R: begin
          r_exp   <= incdec_b;
          r_cnt   <= r_cnt + 4'd1;
          r_state <= c_DONE;
          if (incdec_b == c_EXP_MAX) begin
            r_ovf  <= 1'b1;
            r_mant <= 12'd0;
          end else begin
            r_mant <= w_mant_shr;
          end
        end
        c_SHIFT_L: begin
          if (r_exp == c_EXP_MIN) begin
            r_unf   <= 1'b1;
            r_exp   <= 5'd0;
            r_state <= c_DONE;
          end else begin
            r_mant <= w_mant_shl;
            r_exp  <= incdec_b;
            r_cnt  <= r_cnt + 4'd1;
            if (w_mant_shl[10]) begin
              r_state <= c_DONE;
            end
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_normalize_fsm.sv
`default_nettype none
// ============================================================================
// tb_fp16_normalize_fsm : randomized bench with a behavioural normalizer model
// Revision 1.0
// ============================================================================
module tb_fp16_normalize_fsm;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [11:0] sum_in;
  logic        incdec_select;
  logic        incdec_cin;
  logic [4:0]  incdec_a;
  logic [4:0]  incdec_b;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out;
  logic [4:0]  exp_out;
  logic [9:0]  mant_out;
  logic        overflow;
  logic        underflow;
  logic        zero;
  logic [3:0]  shift_cnt;

  fp16_normalize_fsm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .sum_in(sum_in),
    .incdec_select(incdec_select), .incdec_cin(incdec_cin),
    .incdec_a(incdec_a), .incdec_b(incdec_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .overflow(overflow), .underflow(underflow), .zero(zero),
    .shift_cnt(shift_cnt)
  );

  // External controlled increment/decrement unit.
  assign incdec_b = !incdec_select ? incdec_a :
                    (incdec_cin ? incdec_a - 5'd1 : incdec_a + 5'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int e;
    int m;
    bit ovf;
    bit unf;
    bit z;
    int cnt;
    int lat;
    bit right;
  } res_t;

  int n_vec = 0;
  int n_err = 0;
  int n_hs = 0;
  int n_sent = 0;
  int n_abort = 0;
  int rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

  function automatic void chk(string nm, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // Result and latency (edges after acceptance until out_valid) from the format rules.
  function automatic res_t model(input int e, input logic [11:0] s);
    res_t r;
    int lz;
    logic [11:0] t;
    r = '{default: 0};
    r.lat = 2;
    r.e = e;
    r.m = int'(s[9:0]);
    if (s == 12'd0) begin
      r.z = 1; r.e = 0; r.m = 0;
    end else if (e == 31) begin
      r.ovf = 1; r.m = 0;
    end else if (e == 0) begin
      r.lat = 2;
    end else if (s[11]) begin
      r.right = 1; r.cnt = 1; r.lat = 3; r.e = e + 1;
      t = s >> 1;
      r.m = int'(t[9:0]);
      if (e + 1 == 31) begin r.ovf = 1; r.m = 0; end
    end else if (!s[10]) begin
      lz = 0;
      while (s[10 - lz] == 1'b0) lz++;
      if (e > lz) begin
        r.cnt = lz; r.e = e - lz; r.lat = 2 + lz;
        t = s << lz;
      end else begin
        r.cnt = e - 1; r.unf = 1; r.e = 0; r.lat = 2 + e;
        t = s << (e - 1);
      end
      r.m = int'(t[9:0]);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Per-cycle compare against the model for the transaction in flight.
  res_t ex;
  int   e_in;
  int   sg_in;
  int   n;
  bit   busy = 0;

  always @(negedge clk) begin
    int xs, xc, xa;
    if (!rst_n) begin
      busy = 0;
    end else if (busy) begin
      n++;
      chk("in_ready_busy", int'(in_ready), 0);
      chk("out_valid", int'(out_valid), int'(n >= ex.lat));
      if (n < ex.lat) begin
        xs = 0; xc = 0; xa = e_in;
        if (n >= 2) begin
          if (ex.right) begin
            xs = 1;
          end else begin
            xa = (e_in - (n - 2)) & 31;
            xs = int'(!(ex.unf && n == ex.lat - 1));
            xc = xs;
          end
        end
        chk("incdec_select", int'(incdec_select), xs);
        chk("incdec_cin", int'(incdec_cin), xc);
        chk("incdec_a", int'(incdec_a), xa);
      end else begin
        chk("exp_out", int'(exp_out), ex.e);
        chk("mant_out", int'(mant_out), ex.m);
        chk("sign_out", int'(sign_out), sg_in);
        chk("overflow", int'(overflow), int'(ex.ovf));
        chk("underflow", int'(underflow), int'(ex.unf));
        chk("zero", int'(zero), int'(ex.z));
        chk("shift_cnt", int'(shift_cnt), ex.cnt);
        chk("incdec_select_done", int'(incdec_select), 0);
        if (out_ready) begin
          n_hs++;
          busy = 0;
        end
      end
    end else begin
      chk("in_ready_idle", int'(in_ready), 1);
      chk("out_valid_idle", int'(out_valid), 0);
      if (in_valid) begin
        ex = model(int'(exp_in), sum_in);
        e_in = int'(exp_in);
        sg_in = int'(sign_in);
        n = 0;
        busy = 1;
      end
    end
  end

  task automatic send(input logic sg, input logic [4:0] e, input logic [11:0] s);
    int i;
    @(posedge clk);
    #1;
    in_valid = 1'b1; sign_in = sg; exp_in = e; sum_in = s;
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_sent++;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (busy) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_fields"}, int'({sign_out, exp_out, mant_out}), 0);
    chk({tag, "_flags"}, int'({overflow, underflow, zero}), 0);
    chk({tag, "_shift_cnt"}, int'(shift_cnt), 0);
    chk({tag, "_incdec"}, int'({incdec_select, incdec_cin}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    int hs0;
    int cat;
    logic [11:0] s;
    logic [4:0]  e;
    int edges[5] = '{0, 1, 2, 30, 31};

    rst_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0; exp_in = 5'd0; sum_in = 12'd0;

    // Hand-derived results pin the model.
    r = model(15, 12'h600);
    chk("pin_norm", r.e * 100000 + r.m * 10 + r.lat, 15 * 100000 + 12'h200 * 10 + 2);
    r = model(15, 12'hC01);
    chk("pin_carry", r.e * 100000 + r.m * 10 + r.lat, 16 * 100000 + 12'h200 * 10 + 3);
    r = model(20, 12'h010);
    chk("pin_left", r.e * 100000 + r.m * 100 + r.cnt * 10 + r.lat, 14 * 100000 + 0 + 60 + 8);
    r = model(30, 12'h800);
    chk("pin_ovf", int'(r.ovf) * 1000 + r.e * 10 + r.m, 1000 + 310);
    r = model(2, 12'h100);
    chk("pin_unf", int'(r.unf) * 100000 + r.m * 100 + r.cnt * 10 + r.lat, 100000 + 12'h200 * 100 + 10 + 4);
    r = model(9, 12'h000);
    chk("pin_zero", int'(r.z) * 100 + r.e, 100);

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors from the test plan.
    rdy_mode = 2;
    send(1'b1, 5'd15, 12'h600);
    send(1'b0, 5'd15, 12'hC01);
    send(1'b0, 5'd20, 12'h010);
    send(1'b0, 5'd30, 12'h800);
    send(1'b1, 5'd2,  12'h100);
    send(1'b0, 5'd9,  12'h000);
    send(1'b0, 5'd1,  12'h040);
    send(1'b1, 5'd0,  12'hC55);
    wait_idle();

    // Hold out_ready low in DONE, then release for exactly one transfer.
    rdy_mode = 1;
    send(1'b1, 5'd15, 12'h600);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("hold_reached_done", int'(out_valid), 1);
    repeat (5) @(negedge clk);
    hs0 = n_hs;
    rdy_mode = 2;
    repeat (4) @(negedge clk);
    chk("hold_single_transfer", n_hs - hs0, 1);

    // Asynchronous reset during SHIFT_L.
    send(1'b1, 5'd20, 12'h010);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    n_abort++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("midreset_in_ready_after", int'(in_ready), 1);

    // Randomized traffic with random downstream backpressure.
    rdy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      cat = $urandom_range(0, 4);
      case (cat)
        0: s = 12'($urandom);
        1: s = 12'($urandom_range(0, 1023) >> $urandom_range(0, 9));
        2: s = 12'h800 | 12'($urandom);
        3: s = 12'h400 | 12'($urandom_range(0, 1023));
        default: s = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'(1 << $urandom_range(0, 11));
      endcase
      if ($urandom_range(0, 3) == 0) e = 5'(edges[$urandom_range(0, 4)]);
      else e = 5'($urandom_range(0, 31));
      send(1'($urandom_range(0, 1)), e, s);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    rdy_mode = 2;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("handshake_count", n_hs, n_sent - n_abort);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp16_normalize_fsm.md
# fp16_normalize_fsm

Iterative post-add normalizer for the half-precision adder. It accepts the raw 12-bit mantissa sum, exponent and sign from the add/subtract stage. It normalizes the mantissa one bit per cycle and steps the exponent through the controlled increment/decrement unit, which sits directly downstream on the exponent path. The packed result is returned with overflow, underflow and zero flags over a valid/ready handshake.

## Interface
- No parameters; widths are fixed by the fp16 format: 5-bit exponent, 10-bit fraction.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a sum.
- in_ready  out  1  high only in IDLE.
- sign_in  in  1  result sign; passed through unchanged.
- exp_in  in  5  biased exponent of the larger operand.
- sum_in  in  12  mantissa sum: bit 11 = carry, bit 10 = hidden bit, bits 9:0 = fraction.
- incdec_select  out  1  drives the inc/dec unit's select input; 1 = change exponent.
- incdec_cin  out  1  drives the inc/dec unit's Cin input; 1 = decrement, 0 = increment.
- incdec_a  out  5  exponent operand to the inc/dec unit; equals the exponent register.
- incdec_b  in  5  combinational result from the inc/dec unit.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- sign_out, exp_out[4:0], mant_out[9:0]  out  packed fp16 result fields.
- overflow, underflow, zero  out  1 each  result flags, valid while out_valid is high.
- shift_cnt  out  4  number of shift steps taken for the current result.

## Operation
- States: IDLE, CHECK, SHIFT_R, SHIFT_L, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch sign, exp and mant registers; clear flags and shift_cnt; go to CHECK.
- CHECK, evaluated in this priority order:
  - mant==0: set zero=1, exp=0; go to DONE.
  - exp==31: set overflow=1, mant=0; go to DONE.
  - exp==0: denormal passthrough, unchanged; go to DONE.
  - mant[11]==1: go to SHIFT_R.
  - mant[10]==1: go to DONE.
  - Otherwise: go to SHIFT_L.
- SHIFT_R (one cycle)
  - Drive incdec_select=1, incdec_cin=0.
  - mant <= mant>>1; the dropped LSB is truncated.
  - exp <= incdec_b; shift_cnt++.
  - If incdec_b==31: set overflow=1, mant=0 (infinity).
  - Go to DONE.
- SHIFT_L, repeats one cycle per step:
  - If exp==1: set underflow=1, exp <= 0, mant unchanged (denormal encoding); go to DONE.
  - Else: drive incdec_select=1, incdec_cin=1; mant <= mant<<1; exp <= incdec_b; shift_cnt++.
  - If the shifted mant[10]==1, go to DONE; otherwise stay in SHIFT_L.
- In every state except SHIFT_R and SHIFT_L: incdec_select=0, incdec_cin=0.
- DONE
  - out_valid=1.
  - Outputs: mant_out=mant[9:0], exp_out=exp, sign_out=sign.
  - All outputs hold stable until out_ready; on out_valid&&out_ready go to IDLE.
- Arithmetic
  - The exponent is never computed locally; every change comes from incdec_b, sampled in the same cycle it is driven.
  - mant is 12 bits. The left shift fills with 0. The right shift fills bit 11 with 0.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0.
  - exp_out=0, mant_out=0, sign_out=0.
  - overflow, underflow, zero = 0; shift_cnt=0.
  - incdec_select=0, incdec_cin=0.
- Counting from acceptance edge T:
  - CHECK occupies cycle T+1.
  - Already normalized: out_valid rises at T+2.
  - Right shift: out_valid rises at T+3.
  - k left shifts: out_valid rises at T+2+k, with k ≤ 10.
  - Underflow stop: out_valid rises one cycle after the cycle in which exp==1 is detected.
- Throughput: one result in flight. in_ready=0 from T+1 until the DONE handshake completes.
- Back-to-back: new input is accepted no earlier than the cycle after the out handshake (IDLE).
- out_ready held low: DONE persists indefinitely and all outputs stay constant.
- rst_n asserted mid-operation: immediate return to reset values; the in-flight result is discarded with no out_valid.
- incdec_* are combinational from state and exp register; no registered output path.

## Test plan
- Already normalized:
  - Stimulus: exp_in=15, sum_in=0x600, sign_in=1.
  - Required: out_valid at T+2, exp_out=15, mant_out=0x200, sign_out=1, shift_cnt=0, no flags.
- Carry out:
  - Stimulus: exp_in=15, sum_in=0xC01.
  - Required: out_valid at T+3, exp_out=16, mant_out=0x200 (LSB truncated), shift_cnt=1, incdec_select=1 and incdec_cin=0 during SHIFT_R.
- Left normalize:
  - Stimulus: exp_in=20, sum_in=0x010.
  - Required: 6 SHIFT_L cycles with incdec_cin=1, exp_out=14, mant_out=0x000, shift_cnt=6, out_valid at T+8.
- Edge flags:
  - Stimulus 1: exp_in=30, sum_in=0x800. Required: overflow=1, exp_out=31, mant_out=0.
  - Stimulus 2: exp_in=2, sum_in=0x100. Required: one shift, then underflow=1, exp_out=0, mant_out=0x200.
  - Stimulus 3: sum_in=0. Required: zero=1, exp_out=0.
- Handshake and reset:
  - Stimulus 1: hold out_ready=0 for 5 cycles in DONE. Required: outputs stable, in_ready=0; single transfer when out_ready rises.
  - Stimulus 2: assert rst_n=0 during SHIFT_L. Required: all outputs return to reset values asynchronously; in_ready=1 after release.
